division: RTL
=============

Name: division

Overview:
- Signed sequential integer divider, the inverse of the Booth multiplier in the arithmetic unit.
- Divides a 2N-bit two's-complement dividend (multiplier-product width) by an N-bit two's-complement divisor.
- Produces an N-bit quotient and N-bit remainder using radix-2 restoring division on magnitudes, then applies a sign fix-up.
- Uses the same valid/done handshake as the multiplier, so both share one controller slot.

Parameters:
N, 8, operand width; dividend is 2N bits, divisor/quotient/remainder N bits; iteration count is 2N.

Ports:
clk  input  1  single system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
valid  input  1  start request, sampled only in IDLE
A  input  2N  signed dividend
B  input  N  signed divisor
Q  output  N  signed quotient, registered
R  output  N  signed remainder, registered
done  output  1  one-cycle pulse, results valid
busy  output  1  high whenever state != IDLE
ovf  output  1  quotient overflow flag, registered with Q
dz  output  1  divide-by-zero flag, registered with Q

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; Q, R, ovf, dz, done, busy = 0; all internal registers 0. Reset mid-operation aborts with no done.
- States: IDLE, LOAD, ITER, FIXUP, DONE.
- IDLE: if valid, capture A, B, sign_q = A[2N-1]^B[N-1], sign_r = A[2N-1] -> LOAD. valid is ignored in every other state; operands never re-sample while busy.
- LOAD: amag = |A| (2N bits, unsigned, so -2^(2N-1) is representable); dmag = |B| (N+1 bits). rem = 0 (N+1 bits), quo = amag, count = 0.
  - B == 0 -> FIXUP with dz flagged.
  - Otherwise -> ITER.
- ITER, one step per cycle, 2N cycles:
  - {rem, quo} <<= 1.
  - trial = rem - dmag (N+2-bit compare).
  - If trial >= 0: rem = trial, quo[0] = 1.
  - count++; at count == 2N-1 -> FIXUP.
- FIXUP writes Q, R, ovf, dz; -> DONE.
  - dz: Q = sign_r ? 2^(N-1) (0x80) : 2^(N-1)-1 (0x7F); R = 0; ovf = 0; dz = 1.
  - Overflow: quo > 2^(N-1)-1 with sign_q=0, or quo > 2^(N-1) with sign_q=1. Then Q saturates (0x7F positive, 0x80 negative), R = 0, ovf = 1, dz = 0.
  - Else: Q = sign_q ? -quo : quo (low N bits); R = sign_r ? -rem : rem (low N bits); ovf = dz = 0.
  - Truncation toward zero; remainder carries the dividend's sign.
- DONE: done = 1 for exactly this cycle -> IDLE. A valid held high re-starts on the following IDLE cycle (no back-to-back start from DONE).
- Latency, edge 0 = the edge that samples valid: done is high in the cycle after edge 18 (normal) or after edge 2 (dz).
- Outputs hold their last result until the next FIXUP. Q and R are not cleared at start.

Decomposition:
- Shared package arith_pkg, holding:
  - mult_control_t (moved from the multiplier);
  - new div_control_t {load_ops, init_iter, step, write_result};
  - div_state_t enum;
  - localparam ARITH_N = 8.
- One natural sub-module: division_datapath, containing the magnitude/abs logic, the {rem,quo} shift register, trial subtractor and fix-up mux, driven by div_control_t.
- The FSM stays in division, mirroring the multiplier's FSM/datapath split.

Test Plan:
- A=100, B=7 -> Q=14 (0x0E), R=2, ovf=0, dz=0; done exactly 18 cycles after the start edge, width 1 cycle; busy high in between.
- A=-100, B=7 -> Q=-14 (0xF2), R=-2 (0xFE). A=1000, B=-10 -> Q=-100 (0x9C), R=0.
- Overflow: A=1000, B=3 -> Q=0x7F, R=0, ovf=1. A=-32768, B=-1 -> Q=0x7F, ovf=1. A=-1024, B=8 -> Q=0x80 (-128), ovf=0.
- A=5, B=0 -> dz=1, Q=0x7F, R=0, done 2 cycles after start. A=-5, B=0 -> Q=0x80.
- valid toggled and A/B changed while busy -> no effect on result; Q/R hold the previous result until FIXUP.
- rst driven low mid-ITER (cycle 9) -> immediately all outputs 0, state IDLE, no done. A new valid after release completes normally.

Source files
------------

// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg: types and constants shared by the arithmetic unit.
//   ARITH_N        : operand width used by the Booth multiplier and divider
//   mult_control_t : control word from the multiplier FSM to its datapath
//   div_control_t  : control word from the divider FSM to its datapath
//   div_state_t    : divider FSM state encoding
// ---------------------------------------------------------------------------
package arith_pkg;

  localparam int ARITH_N = 8;

  // Multiplier control word.
  typedef struct packed {
    logic load_ops;
    logic add;
    logic sub;
    logic shift;
    logic write_result;
  } mult_control_t;

  // Divider control word. At most one field is set in any cycle.
  typedef struct packed {
    logic load_ops;      // capture A/B and the result signs
    logic init_iter;     // compute magnitudes, clear rem, load quo
    logic step;          // one restoring-division step
    logic write_result;  // sign fix-up / saturation into Q, R, ovf, dz
  } div_control_t;

  typedef enum logic [2:0] {
    DIV_IDLE  = 3'd0,
    DIV_LOAD  = 3'd1,
    DIV_ITER  = 3'd2,
    DIV_FIXUP = 3'd3,
    DIV_DONE  = 3'd4
  } div_state_t;

endpackage

// File: rtl/division_datapath.sv
// ---------------------------------------------------------------------------
// division_datapath: operand capture, magnitude logic, the {rem,quo} shift
// register with its trial subtractor, and the result fix-up mux.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ctrl       : div_control_t from the FSM in division
//   a_in, b_in : signed dividend (2N bits) / divisor (N bits)
//   b_zero     : captured divisor is zero (steers the FSM out of LOAD)
//   q, r       : registered signed quotient / remainder
//   ovf, dz    : registered overflow / divide-by-zero flags
// ---------------------------------------------------------------------------
module division_datapath
  import arith_pkg::*;
#(
  parameter int N = ARITH_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  div_control_t   ctrl,
  input  logic [2*N-1:0] a_in,
  input  logic [N-1:0]   b_in,
  output logic           b_zero,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           ovf,
  output logic           dz
);

  // Largest magnitudes that fit the signed N-bit quotient.
  localparam logic [2*N-1:0] QMAX_POS = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [2*N-1:0] QMAX_NEG = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]   SAT_POS  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]   SAT_NEG  = {1'b1, {(N-1){1'b0}}};

  logic [2*N-1:0] a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           sgn_quo_q, sgn_quo_d;
  logic           sgn_rem_q, sgn_rem_d;
  logic [N:0]     dmag_q, dmag_d;
  logic [N:0]     rem_q, rem_d;
  logic [2*N-1:0] quo_q, quo_d;
  logic           dz_pend_q, dz_pend_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   r_q, r_d;
  logic           ovf_q, ovf_d;
  logic           dz_q, dz_d;

  logic [2*N-1:0] amag;
  logic [N:0]     bext;
  logic [N:0]     dmag;
  logic [N:0]     rem_sh;
  logic [2*N-1:0] quo_sh;
  logic [N+1:0]   trial;
  logic           quo_ovf;

  always_comb begin
    // 2N-bit unsigned magnitude: -2^(2N-1) maps onto itself, which is the
    // correct unsigned value.
    amag = a_q[2*N-1] ? ({(2*N){1'b0}} - a_q) : a_q;
    // Divisor magnitude needs N+1 bits so that -2^(N-1) stays positive.
    bext = {b_q[N-1], b_q};
    dmag = b_q[N-1] ? ({(N+1){1'b0}} - bext) : bext;

    // rem < dmag <= 2^(N-1), so the shifted remainder fits in N+1 bits and
    // the extra top bit of trial is a clean borrow/sign bit.
    rem_sh = {rem_q[N-1:0], quo_q[2*N-1]};
    quo_sh = {quo_q[2*N-2:0], 1'b0};
    trial  = {1'b0, rem_sh} - {1'b0, dmag_q};

    quo_ovf = sgn_quo_q ? (quo_q > QMAX_NEG) : (quo_q > QMAX_POS);

    a_d       = a_q;
    b_d       = b_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    dmag_d    = dmag_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dz_pend_d = dz_pend_q;
    q_d       = q_q;
    r_d       = r_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;

    if (ctrl.load_ops) begin
      a_d       = a_in;
      b_d       = b_in;
      sgn_quo_d = a_in[2*N-1] ^ b_in[N-1];
      sgn_rem_d = a_in[2*N-1];
    end

    if (ctrl.init_iter) begin
      dmag_d    = dmag;
      rem_d     = '0;
      quo_d     = amag;
      dz_pend_d = (b_q == '0);
    end

    if (ctrl.step) begin
      if (!trial[N+1]) begin
        rem_d = trial[N:0];
        quo_d = quo_sh | {{(2*N-1){1'b0}}, 1'b1};
      end else begin
        rem_d = rem_sh;
        quo_d = quo_sh;
      end
    end

    if (ctrl.write_result) begin
      if (dz_pend_q) begin
        // Divide by zero saturates toward the dividend's sign.
        q_d   = sgn_rem_q ? SAT_NEG : SAT_POS;
        r_d   = '0;
        ovf_d = 1'b0;
        dz_d  = 1'b1;
      end else if (quo_ovf) begin
        q_d   = sgn_quo_q ? SAT_NEG : SAT_POS;
        r_d   = '0;
        ovf_d = 1'b1;
        dz_d  = 1'b0;
      end else begin
        q_d   = sgn_quo_q ? ({N{1'b0}} - quo_q[N-1:0]) : quo_q[N-1:0];
        r_d   = sgn_rem_q ? ({N{1'b0}} - rem_q[N-1:0]) : rem_q[N-1:0];
        ovf_d = 1'b0;
        dz_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      dmag_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dz_pend_q <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      dmag_q    <= dmag_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dz_pend_q <= dz_pend_d;
      q_q       <= q_d;
      r_q       <= r_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
    end
  end

  assign b_zero = (b_q == '0);
  assign q      = q_q;
  assign r      = r_q;
  assign ovf    = ovf_q;
  assign dz     = dz_q;

endmodule

// File: rtl/division.sv
// ---------------------------------------------------------------------------
// division: signed sequential divider (2N-bit dividend / N-bit divisor),
// radix-2 restoring division on magnitudes followed by a sign fix-up.
// Quotient truncates toward zero; remainder takes the dividend's sign.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   valid     : start request, sampled only in IDLE
//   A, B      : signed dividend (2N) / divisor (N)
//   Q, R      : registered signed quotient / remainder, held until next result
//   done      : one-cycle pulse when Q/R/ovf/dz are valid
//   busy      : high whenever the FSM is not IDLE
//   ovf, dz   : quotient overflow / divide-by-zero flags
//   dbg_state : current FSM state (div_state_t encoding)
//
// Handshake: a start is accepted on a rising edge where valid is high and the
// FSM is IDLE; valid is ignored otherwise and the operands are captured only
// at that edge. done pulses in the DONE state, after which the FSM returns to
// IDLE; a valid still high then starts a new operation one cycle later.
// ---------------------------------------------------------------------------
module division
  import arith_pkg::*;
#(
  parameter int N = ARITH_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid,
  input  logic [2*N-1:0] A,
  input  logic [N-1:0]   B,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   R,
  output logic           done,
  output logic           busy,
  output logic           ovf,
  output logic           dz,
  output logic [2:0]     dbg_state
);

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0] LAST_STEP = CW'(2*N-1);

  div_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  div_control_t  ctrl;
  logic          b_zero;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ctrl    = '0;
    case (state_q)
      DIV_IDLE: begin
        if (valid) begin
          ctrl.load_ops = 1'b1;
          state_d       = DIV_LOAD;
        end
      end
      DIV_LOAD: begin
        ctrl.init_iter = 1'b1;
        count_d        = '0;
        state_d        = b_zero ? DIV_FIXUP : DIV_ITER;
      end
      DIV_ITER: begin
        ctrl.step = 1'b1;
        count_d   = count_q + 1'b1;
        if (count_q == LAST_STEP) state_d = DIV_FIXUP;
      end
      DIV_FIXUP: begin
        ctrl.write_result = 1'b1;
        state_d           = DIV_DONE;
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  division_datapath #(.N(N)) u_datapath (
    .clk    (clk),
    .rst_n  (rst),
    .ctrl   (ctrl),
    .a_in   (A),
    .b_in   (B),
    .b_zero (b_zero),
    .q      (Q),
    .r      (R),
    .ovf    (ovf),
    .dz     (dz)
  );

  assign done      = (state_q == DIV_DONE);
  assign busy      = (state_q != DIV_IDLE);
  assign dbg_state = state_q;

endmodule
